// File: rtl/data_memory_sync.sv
// Single-port word-addressed RAM with valid/ready requests, byte enables and a
// self-clearing init pass after every reset. Responses return READ_LAT cycles after acceptance.
module data_memory_sync #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 16,
    parameter int READ_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                req_ready,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_done
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             in_range;
    logic             rd_en;
    logic [IDX_W-1:0] req_idx;

    logic [NB-1:0]     mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] ram_rd_q;

    logic s1_valid_q, s1_err_q, s1_rd_q;

    logic              out_valid;
    logic              out_err;
    logic              out_rd;
    logic [DATA_W-1:0] out_data;

    assign accept   = req_valid && (state_q == RUN);
    assign in_range = {1'b0, req_addr} < DEPTH_X;
    // Index is forced to zero for out-of-range addresses so aliasing can never reach the array.
    assign req_idx  = in_range ? req_addr[IDX_W-1:0] : '0;
    assign rd_en    = accept && !req_write && in_range;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + IDX_W'(1);
            if (cnt_q == LAST_IDX) begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end
    end

    // The clear pass and request writes share the single array write port.
    always_comb begin
        mem_we    = '0;
        mem_idx   = cnt_q;
        mem_wdata = '0;
        if (state_q == INIT) begin
            mem_we = '1;
        end else if (accept && req_write && in_range) begin
            mem_we    = req_be;
            mem_idx   = req_idx;
            mem_wdata = req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (mem_we[b]) begin
                mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        if (rd_en) begin
            ram_rd_q <= mem_q[req_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_rd_q    <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            s1_err_q   <= accept && !in_range;
            s1_rd_q    <= rd_en;
        end
    end

    generate
        if (READ_LAT >= 2) begin : g_lat2
            logic              s2_valid_q, s2_err_q, s2_rd_q;
            logic [DATA_W-1:0] s2_data_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s2_valid_q <= 1'b0;
                    s2_err_q   <= 1'b0;
                    s2_rd_q    <= 1'b0;
                end else begin
                    s2_valid_q <= s1_valid_q;
                    s2_err_q   <= s1_err_q;
                    s2_rd_q    <= s1_rd_q;
                end
            end

            always_ff @(posedge clk) begin
                if (s1_rd_q) begin
                    s2_data_q <= ram_rd_q;
                end
            end

            assign out_valid = s2_valid_q;
            assign out_err   = s2_err_q;
            assign out_rd    = s2_rd_q;
            assign out_data  = s2_data_q;
        end else begin : g_lat1
            assign out_valid = s1_valid_q;
            assign out_err   = s1_err_q;
            assign out_rd    = s1_rd_q;
            assign out_data  = ram_rd_q;
        end
    endgenerate

    // The data path has no reset, so read data is gated by the reset-cleared read flag.
    assign rsp_valid = out_valid;
    assign rsp_err   = out_err;
    assign rsp_rdata = out_rd ? out_data : '0;
    assign req_ready = (state_q == RUN);
    assign init_done = (state_q == RUN);

endmodule

// File: tb/tb_data_memory_sync.sv
// Drives one request stream into READ_LAT=1 and READ_LAT=2 instances and checks
// both against a word-array reference model through per-instance response queues.
module tb_data_memory_sync;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;

    logic        ready1, v1, e1, done1;
    logic [15:0] d1;
    logic        ready2, v2, e2, done2;
    logic [15:0] d2;

    always #5 clk = ~clk;

    data_memory_sync #(.DATA_W(16), .ADDR_W(16), .DEPTH(16), .READ_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .req_ready(ready1), .rsp_valid(v1), .rsp_rdata(d1), .rsp_err(e1),
        .init_done(done1)
    );

    data_memory_sync #(.DATA_W(16), .ADDR_W(16), .DEPTH(16), .READ_LAT(2)) u_lat2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .req_ready(ready2), .rsp_valid(v2), .rsp_rdata(d2), .rsp_err(e2),
        .init_done(done2)
    );

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    logic [15:0] model [16];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    endtask

    // Drive one request for one cycle; an instance that shows ready accepts it at the next edge.
    task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                         input logic [1:0] be);
        exp_t x;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        x.err  = (addr >= 16);
        x.data = 16'h0000;
        x.cyc  = 0;
        if (ready1 || ready2) begin
            if (!x.err) begin
                if (wr) begin
                    for (int b = 0; b < 2; b++)
                        if (be[b]) model[addr[3:0]][8*b +: 8] = wd[8*b +: 8];
                end else begin
                    x.data = model[addr[3:0]];
                end
            end
            if (ready1) begin x.cyc = cyc + 1; q1.push_back(x); end
            if (ready2) begin x.cyc = cyc + 2; q2.push_back(x); end
        end
        $display("req cyc=%0d %s addr=%h wdata=%h be=%b", cyc, wr ? "WR" : "RD", addr, wd, be);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_init();
        int count = 0;
        while (!(ready1 && ready2) && count < 100) begin
            count++;
            @(negedge clk);
        end
        check("init_cycles", 32'(count), 32'd16);
        check("init_done_lat1", {31'd0, done1}, 32'd1);
        check("init_done_lat2", {31'd0, done2}, 32'd1);
    endtask

    // Assert reset just after a rising edge, so responses already in the pipeline are cut off.
    task automatic hard_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        q1.delete();
        q2.delete();
        clear_model();
        check("rst_ready1", {31'd0, ready1}, 32'd0);
        check("rst_done1",  {31'd0, done1},  32'd0);
        check("rst_valid1", {31'd0, v1},     32'd0);
        check("rst_err1",   {31'd0, e1},     32'd0);
        check("rst_rdata1", {16'd0, d1},     32'd0);
        check("rst_ready2", {31'd0, ready2}, 32'd0);
        check("rst_done2",  {31'd0, done2},  32'd0);
        check("rst_valid2", {31'd0, v2},     32'd0);
        check("rst_err2",   {31'd0, e2},     32'd0);
        check("rst_rdata2", {16'd0, d2},     32'd0);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_init();
    endtask

    task automatic mon(input int p, input logic v, input logic [15:0] d, input logic e);
        exp_t x;
        bit   have;
        string tag;
        have = 1'b0;
        tag  = (p == 0) ? "lat1" : "lat2";
        if (v) begin
            if (p == 0 && q1.size() > 0) begin x = q1.pop_front(); have = 1'b1; end
            if (p == 1 && q2.size() > 0) begin x = q2.pop_front(); have = 1'b1; end
            if (!have) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s unexpected_rsp: got rsp_valid=1, expected 0 (cycle %0d)", tag, cyc);
            end else begin
                $display("rsp %s cyc=%0d rdata=%h err=%b", tag, cyc, d, e);
                check({tag, "_rsp_cycle"}, 32'(cyc), 32'(x.cyc));
                check({tag, "_rsp_rdata"}, {16'd0, d}, {16'd0, x.data});
                check({tag, "_rsp_err"}, {31'd0, e}, {31'd0, x.err});
            end
        end else begin
            check({tag, "_idle_rdata"}, {16'd0, d}, 32'd0);
            check({tag, "_idle_err"}, {31'd0, e}, 32'd0);
            if (p == 0 && q1.size() > 0 && q1[0].cyc <= cyc) begin
                x = q1.pop_front();
                n_checks++; n_fail++;
                $display("FAIL %s missing_rsp: got rsp_valid=0, expected 1 at cycle %0d", tag, x.cyc);
            end
            if (p == 1 && q2.size() > 0 && q2[0].cyc <= cyc) begin
                x = q2.pop_front();
                n_checks++; n_fail++;
                $display("FAIL %s missing_rsp: got rsp_valid=0, expected 1 at cycle %0d", tag, x.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, v1, d1, e1);
        mon(1, v2, d2, e2);
    end

    initial begin
        int r;
        int wait_cnt;
        logic [15:0] a;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
        req_be    = 2'b00;
        clear_model();
        repeat (3) @(negedge clk);

        // Init: a read is held during the clear pass and must be ignored until ready.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'd5;
        reset     = 1'b0;
        wait_init();
        issue(1'b0, 16'd5, 16'h0000, 2'b00);
        idle(3);

        // Write then read back to back.
        issue(1'b1, 16'd1, 16'h0000, 2'b11);
        issue(1'b1, 16'd2, 16'h000F, 2'b11);
        issue(1'b0, 16'd1, 16'h0000, 2'b00);
        issue(1'b0, 16'd2, 16'h0000, 2'b00);
        idle(3);

        // Byte enables, including an all-zero enable.
        issue(1'b1, 16'd3, 16'hA5A5, 2'b11);
        issue(1'b1, 16'd3, 16'h1234, 2'b01);
        issue(1'b0, 16'd3, 16'h0000, 2'b00);
        issue(1'b1, 16'd3, 16'hFFFF, 2'b00);
        issue(1'b0, 16'd3, 16'h0000, 2'b00);
        idle(3);

        // Out-of-range writes, then a full sweep.
        issue(1'b1, 16'd16, 16'hFFFF, 2'b11);
        issue(1'b1, 16'h8000, 16'hFFFF, 2'b11);
        for (int k = 0; k < 16; k++) issue(1'b0, 16'(k), 16'h0000, 2'b00);
        idle(3);

        // Back-to-back stream of writes then reads.
        for (int k = 0; k < 16; k++) issue(1'b1, 16'(k), 16'(k * 16'h0101), 2'b11);
        for (int k = 0; k < 16; k++) issue(1'b0, 16'(k), 16'h0000, 2'b00);
        idle(3);

        // Reset with two reads in flight, then every word must read zero.
        issue(1'b0, 16'd4, 16'h0000, 2'b00);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'd5;
        hard_reset();
        for (int k = 0; k < 16; k++) issue(1'b0, 16'(k), 16'h0000, 2'b00);
        idle(3);

        // Randomised traffic with one mid-stream reset.
        for (int it = 0; it < 400; it++) begin
            if (it == 200) hard_reset();
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 2));
            r = $urandom_range(0, 19);
            if (r < 16)       a = 16'(r);
            else if (r == 16) a = 16'd16;
            else if (r == 17) a = 16'h8000;
            else if (r == 18) a = 16'hFFFF;
            else              a = 16'($urandom_range(16, 65535));
            issue(1'($urandom_range(0, 1)), a, 16'($urandom), 2'($urandom_range(0, 3)));
        end

        idle(1);
        wait_cnt = 0;
        while ((q1.size() > 0 || q2.size() > 0) && wait_cnt < 20) begin
            wait_cnt++;
            @(negedge clk);
        end
        check("drain_lat1", 32'(q1.size()), 32'd0);
        check("drain_lat2", 32'(q2.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
